// File: rtl/tlb_lookup_ctrl.sv
// TLB lookup controller: one-cycle tag compare against external set storage, page-walk on miss,
// LRU/invalid victim selection for refill, and a held response until the consumer accepts it.
module tlb_lookup_ctrl #(
  parameter int unsigned NUM_WAYS       = 4,
  parameter int unsigned SET_INDEX_BITS = 4,
  parameter int unsigned LRU_BITS       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [31:0]                  req_vaddr,
  input  logic                         req_write,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [31:0]                  resp_paddr,
  output logic                         resp_fault,
  output logic                         walk_req_valid,
  input  logic                         walk_req_ready,
  output logic [19:0]                  walk_req_vpn,
  input  logic                         walk_resp_valid,
  input  logic [19:0]                  walk_resp_ppn,
  input  logic [1:0]                   walk_resp_perms,
  output logic [SET_INDEX_BITS-1:0]    rd_set_index,
  input  logic [NUM_WAYS-1:0]          rd_valid,
  input  logic [20*NUM_WAYS-1:0]       rd_vpn,
  input  logic [20*NUM_WAYS-1:0]       rd_ppn,
  input  logic [2*NUM_WAYS-1:0]        rd_perms,
  input  logic [LRU_BITS*NUM_WAYS-1:0] rd_lru_count,
  output logic                         wr_en,
  output logic [1:0]                   wr_way,
  output logic [19:0]                  wr_vpn,
  output logic [19:0]                  wr_ppn,
  output logic [1:0]                   wr_perms,
  output logic [LRU_BITS-1:0]          wr_lru_count,
  output logic                         lru_update_en,
  output logic [1:0]                   lru_way,
  output logic [LRU_BITS-1:0]          lru_value
);

  typedef enum logic [2:0] {StIdle, StLookup, StWalkReq, StWalkWait, StRefill, StResp} state_e;

  state_e        state_q;
  logic [31:0]   vaddr_q;
  logic          write_q;
  logic [19:0]   ppn_q;
  logic [1:0]    perms_q;
  logic [31:0]   paddr_q;
  logic          fault_q;
  logic [19:0]   vpn;

  logic                hit;
  logic [1:0]          hit_way;
  logic [19:0]         hit_ppn;
  logic [1:0]          hit_perms;
  logic [LRU_BITS-1:0] hit_cnt;
  logic                any_inv;
  logic [1:0]          victim;
  logic [LRU_BITS-1:0] min_cnt;
  logic                hit_fault;
  logic                walk_fault;

  assign vpn = vaddr_q[31:12];

  // Descending scan so the lowest matching way is the one left standing.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    hit_ppn   = '0;
    hit_perms = '0;
    hit_cnt   = '0;
    for (int i = int'(NUM_WAYS) - 1; i >= 0; i--) begin
      if (rd_valid[i] && (rd_vpn[i*20 +: 20] == vpn)) begin
        hit       = 1'b1;
        hit_way   = 2'(i);
        hit_ppn   = rd_ppn[i*20 +: 20];
        hit_perms = rd_perms[i*2 +: 2];
        hit_cnt   = rd_lru_count[i*LRU_BITS +: LRU_BITS];
      end
    end
  end

  // Lowest invalid way first; otherwise the smallest LRU count, strict < keeps ties low.
  always_comb begin
    any_inv = 1'b0;
    victim  = '0;
    min_cnt = rd_lru_count[LRU_BITS-1:0];
    for (int i = int'(NUM_WAYS) - 1; i >= 0; i--) begin
      if (!rd_valid[i]) begin
        any_inv = 1'b1;
        victim  = 2'(i);
      end
    end
    if (!any_inv) begin
      for (int i = 1; i < int'(NUM_WAYS); i++) begin
        if (rd_lru_count[i*LRU_BITS +: LRU_BITS] < min_cnt) begin
          min_cnt = rd_lru_count[i*LRU_BITS +: LRU_BITS];
          victim  = 2'(i);
        end
      end
    end
  end

  assign hit_fault  = write_q ? ~hit_perms[1] : ~hit_perms[0];
  assign walk_fault = write_q ? ~perms_q[1]   : ~perms_q[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      vaddr_q <= '0;
      write_q <= 1'b0;
      ppn_q   <= '0;
      perms_q <= '0;
      paddr_q <= '0;
      fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            vaddr_q <= req_vaddr;
            write_q <= req_write;
            state_q <= StLookup;
          end
        end
        StLookup: begin
          if (hit) begin
            fault_q <= hit_fault;
            paddr_q <= hit_fault ? 32'h0 : {hit_ppn, vaddr_q[11:0]};
            state_q <= StResp;
          end else begin
            state_q <= StWalkReq;
          end
        end
        StWalkReq: begin
          if (walk_req_ready) state_q <= StWalkWait;
        end
        StWalkWait: begin
          if (walk_resp_valid) begin
            if (walk_resp_perms == 2'b00) begin
              fault_q <= 1'b1;
              paddr_q <= '0;
              state_q <= StResp;
            end else begin
              ppn_q   <= walk_resp_ppn;
              perms_q <= walk_resp_perms;
              state_q <= StRefill;
            end
          end
        end
        StRefill: begin
          fault_q <= walk_fault;
          paddr_q <= walk_fault ? 32'h0 : {ppn_q, vaddr_q[11:0]};
          state_q <= StResp;
        end
        StResp: begin
          if (resp_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready      = (state_q == StIdle);
  assign resp_valid     = (state_q == StResp);
  assign resp_paddr     = paddr_q;
  assign resp_fault     = fault_q;
  assign walk_req_valid = (state_q == StWalkReq);
  assign walk_req_vpn   = vpn;
  assign rd_set_index   = vpn[SET_INDEX_BITS-1:0];

  assign wr_en        = (state_q == StRefill);
  assign wr_way       = wr_en ? victim : 2'b00;
  assign wr_vpn       = vpn;
  assign wr_ppn       = ppn_q;
  assign wr_perms     = perms_q;
  assign wr_lru_count = wr_en ? LRU_BITS'(1) : '0;

  assign lru_update_en = (state_q == StLookup) && hit;
  assign lru_way       = lru_update_en ? hit_way : 2'b00;
  assign lru_value     = !lru_update_en ? '0 : (&hit_cnt) ? hit_cnt : hit_cnt + 1'b1;

endmodule

// File: tb/tb_tlb_lookup_ctrl.sv
// Directed bench for tlb_lookup_ctrl: a behavioural set store, a vector table of lookups and
// walks, plus hand sequences for LRU tie-breaking and reset during an outstanding walk.
module tb_tlb_lookup_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic        req_write;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_paddr;
  logic        resp_fault;
  logic        walk_req_valid;
  logic        walk_req_ready;
  logic [19:0] walk_req_vpn;
  logic        walk_resp_valid;
  logic [19:0] walk_resp_ppn;
  logic [1:0]  walk_resp_perms;
  logic [3:0]  rd_set_index;
  logic [3:0]  rd_valid;
  logic [79:0] rd_vpn;
  logic [79:0] rd_ppn;
  logic [7:0]  rd_perms;
  logic [15:0] rd_lru_count;
  logic        wr_en;
  logic [1:0]  wr_way;
  logic [19:0] wr_vpn;
  logic [19:0] wr_ppn;
  logic [1:0]  wr_perms;
  logic [3:0]  wr_lru_count;
  logic        lru_update_en;
  logic [1:0]  lru_way;
  logic [3:0]  lru_value;

  tlb_lookup_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_vaddr      (req_vaddr),
    .req_write      (req_write),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_paddr     (resp_paddr),
    .resp_fault     (resp_fault),
    .walk_req_valid (walk_req_valid),
    .walk_req_ready (walk_req_ready),
    .walk_req_vpn   (walk_req_vpn),
    .walk_resp_valid(walk_resp_valid),
    .walk_resp_ppn  (walk_resp_ppn),
    .walk_resp_perms(walk_resp_perms),
    .rd_set_index   (rd_set_index),
    .rd_valid       (rd_valid),
    .rd_vpn         (rd_vpn),
    .rd_ppn         (rd_ppn),
    .rd_perms       (rd_perms),
    .rd_lru_count   (rd_lru_count),
    .wr_en          (wr_en),
    .wr_way         (wr_way),
    .wr_vpn         (wr_vpn),
    .wr_ppn         (wr_ppn),
    .wr_perms       (wr_perms),
    .wr_lru_count   (wr_lru_count),
    .lru_update_en  (lru_update_en),
    .lru_way        (lru_way),
    .lru_value      (lru_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Static set store; refills are recorded by the monitor but not written back.
  logic        s_valid [16][4];
  logic [19:0] s_vpn   [16][4];
  logic [19:0] s_ppn   [16][4];
  logic [1:0]  s_perms [16][4];
  logic [3:0]  s_lru   [16][4];

  always_comb begin
    rd_valid     = '0;
    rd_vpn       = '0;
    rd_ppn       = '0;
    rd_perms     = '0;
    rd_lru_count = '0;
    for (int w = 0; w < 4; w++) begin
      rd_valid[w]           = s_valid[rd_set_index][w];
      rd_vpn[w*20 +: 20]    = s_vpn[rd_set_index][w];
      rd_ppn[w*20 +: 20]    = s_ppn[rd_set_index][w];
      rd_perms[w*2 +: 2]    = s_perms[rd_set_index][w];
      rd_lru_count[w*4 +: 4] = s_lru[rd_set_index][w];
    end
  end

  int          wr_cnt  = 0;
  int          lru_cnt = 0;
  logic [1:0]  m_wr_way;
  logic [19:0] m_wr_vpn;
  logic [19:0] m_wr_ppn;
  logic [1:0]  m_wr_perms;
  logic [3:0]  m_wr_lru;
  logic [1:0]  m_lru_way;
  logic [3:0]  m_lru_val;

  always @(posedge clk) begin
    if (wr_en) begin
      wr_cnt     <= wr_cnt + 1;
      m_wr_way   <= wr_way;
      m_wr_vpn   <= wr_vpn;
      m_wr_ppn   <= wr_ppn;
      m_wr_perms <= wr_perms;
      m_wr_lru   <= wr_lru_count;
    end
    if (lru_update_en) begin
      lru_cnt   <= lru_cnt + 1;
      m_lru_way <= lru_way;
      m_lru_val <= lru_value;
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] vaddr;
    logic        write;
    logic [19:0] wppn;
    logic [1:0]  wperms;
    int          wdelay;
    logic        exp_walk;
    logic        exp_wr;
    logic [1:0]  exp_wr_way;
    logic        exp_lru;
    logic [1:0]  exp_lru_way;
    logic [3:0]  exp_lru_val;
    logic [31:0] exp_paddr;
    logic        exp_fault;
    int          exp_lat;
    int          hold;
  } vec_t;

  vec_t vecs[11];

  task automatic run_vec(input int id, input vec_t v);
    int          k;
    int          wait_cnt;
    int          lat;
    int          wr0;
    int          lru0;
    bit          done;
    bit          walk_seen;
    bit          vpn_stable;
    bit          stable;
    logic [19:0] wvpn;
    logic [31:0] pa;
    logic        ft;
    wr0 = wr_cnt;
    lru0 = lru_cnt;
    k = 0;
    wait_cnt = 0;
    lat = 0;
    done = 0;
    walk_seen = 0;
    vpn_stable = 1;
    stable = 1;
    wvpn = '0;
    pa = '0;
    ft = 1'b0;
    @(negedge clk);
    req_vaddr = v.vaddr;
    req_write = v.write;
    req_valid = 1'b1;
    chk($sformatf("v%0d_req_ready", id), 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (!done && k < 60) begin
      @(negedge clk);
      if (walk_resp_valid) walk_resp_valid = 1'b0;
      if (walk_req_valid) begin
        if (!walk_seen) begin
          walk_seen = 1;
          wvpn = walk_req_vpn;
        end else if (walk_req_vpn !== wvpn) begin
          vpn_stable = 0;
        end
        if (wait_cnt == v.wdelay) walk_req_ready = 1'b1;
        else wait_cnt++;
      end else if (walk_req_ready) begin
        walk_req_ready  = 1'b0;
        walk_resp_valid = 1'b1;
        walk_resp_ppn   = v.wppn;
        walk_resp_perms = v.wperms;
      end
      if (resp_valid) begin
        done = 1;
        lat = k + 1;
        pa = resp_paddr;
        ft = resp_fault;
      end
      k++;
    end
    chk($sformatf("v%0d_resp_seen", id), 32'(done), 32'd1);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      if (!resp_valid || resp_paddr !== pa || resp_fault !== ft) stable = 0;
    end
    if (v.hold > 0) chk($sformatf("v%0d_resp_stable", id), 32'(stable), 32'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk($sformatf("v%0d_resp_drop", id), 32'(resp_valid), 32'd0);
    chk($sformatf("v%0d_idle_ready", id), 32'(req_ready), 32'd1);
    chk($sformatf("v%0d_paddr", id), pa, v.exp_paddr);
    chk($sformatf("v%0d_fault", id), 32'(ft), 32'(v.exp_fault));
    chk($sformatf("v%0d_latency", id), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d_walk", id), 32'(walk_seen), 32'(v.exp_walk));
    if (v.exp_walk) begin
      chk($sformatf("v%0d_walk_vpn", id), 32'(wvpn), 32'(v.vaddr[31:12]));
      chk($sformatf("v%0d_walk_vpn_stable", id), 32'(vpn_stable), 32'd1);
    end
    chk($sformatf("v%0d_wr_count", id), 32'(wr_cnt - wr0), v.exp_wr ? 32'd1 : 32'd0);
    if (v.exp_wr) begin
      chk($sformatf("v%0d_wr_way", id), 32'(m_wr_way), 32'(v.exp_wr_way));
      chk($sformatf("v%0d_wr_vpn", id), 32'(m_wr_vpn), 32'(v.vaddr[31:12]));
      chk($sformatf("v%0d_wr_ppn", id), 32'(m_wr_ppn), 32'(v.wppn));
      chk($sformatf("v%0d_wr_perms", id), 32'(m_wr_perms), 32'(v.wperms));
      chk($sformatf("v%0d_wr_lru", id), 32'(m_wr_lru), 32'd1);
    end
    chk($sformatf("v%0d_lru_count", id), 32'(lru_cnt - lru0), v.exp_lru ? 32'd1 : 32'd0);
    if (v.exp_lru) begin
      chk($sformatf("v%0d_lru_way", id), 32'(m_lru_way), 32'(v.exp_lru_way));
      chk($sformatf("v%0d_lru_val", id), 32'(m_lru_val), 32'(v.exp_lru_val));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0;
    int k;
    vec_t v;
    rst = 1'b0;
    req_valid = 1'b0;
    req_vaddr = '0;
    req_write = 1'b0;
    resp_ready = 1'b0;
    walk_req_ready = 1'b0;
    walk_resp_valid = 1'b0;
    walk_resp_ppn = '0;
    walk_resp_perms = '0;
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < 4; w++) begin
        s_valid[s][w] = 1'b0;
        s_vpn[s][w]   = '0;
        s_ppn[s][w]   = '0;
        s_perms[s][w] = '0;
        s_lru[s][w]   = '0;
      end
    end
    // Set 5: read-only entry, duplicated tag in ways 1/3, saturated counter, the ABCD5 entry.
    s_valid[5][0] = 1; s_vpn[5][0] = 20'h00015; s_ppn[5][0] = 20'h0AAAA; s_perms[5][0] = 2'b01;
    s_lru[5][0] = 4'h0;
    s_valid[5][1] = 1; s_vpn[5][1] = 20'h77775; s_ppn[5][1] = 20'h11111; s_perms[5][1] = 2'b11;
    s_lru[5][1] = 4'hF;
    s_valid[5][2] = 1; s_vpn[5][2] = 20'hABCD5; s_ppn[5][2] = 20'h12345; s_perms[5][2] = 2'b11;
    s_lru[5][2] = 4'h7;
    s_valid[5][3] = 1; s_vpn[5][3] = 20'h77775; s_ppn[5][3] = 20'h33333; s_perms[5][3] = 2'b11;
    s_lru[5][3] = 4'h2;
    // Set 9: ways 1 and 2 invalid. Set 11: full with counts 5,4,6,2.
    s_valid[9][0] = 1; s_vpn[9][0] = 20'h00009; s_lru[9][0] = 4'h4;
    s_valid[9][3] = 1; s_vpn[9][3] = 20'h00019; s_lru[9][3] = 4'h0;
    for (int w = 0; w < 4; w++) begin
      s_valid[11][w] = 1;
      s_vpn[11][w]   = 20'h0000B + 20'(w * 16);
    end
    s_lru[11][0] = 4'd5; s_lru[11][1] = 4'd4; s_lru[11][2] = 4'd6; s_lru[11][3] = 4'd2;

    //           vaddr         wr  wppn      wperms d  walk wr way   lru lway lval paddr        flt lat hold
    vecs[0]  = '{32'hABCD5678, 0, 20'h0,     2'b00, 0, 0,   0, 2'd0, 1, 2'd2, 4'h8, 32'h12345678, 0, 2, 0};
    vecs[1]  = '{32'hABCD5678, 1, 20'h0,     2'b00, 0, 0,   0, 2'd0, 1, 2'd2, 4'h8, 32'h12345678, 0, 2, 2};
    vecs[2]  = '{32'h00015123, 1, 20'h0,     2'b00, 0, 0,   0, 2'd0, 1, 2'd0, 4'h1, 32'h00000000, 1, 2, 0};
    vecs[3]  = '{32'h00015123, 0, 20'h0,     2'b00, 0, 0,   0, 2'd0, 1, 2'd0, 4'h1, 32'h0AAAA123, 0, 2, 0};
    vecs[4]  = '{32'h77775ABC, 0, 20'h0,     2'b00, 0, 0,   0, 2'd0, 1, 2'd1, 4'hF, 32'h11111ABC, 0, 2, 0};
    vecs[5]  = '{32'h11113ABC, 0, 20'h22222, 2'b01, 0, 1,   1, 2'd0, 0, 2'd0, 4'h0, 32'h22222ABC, 0, 5, 0};
    vecs[6]  = '{32'h44443000, 1, 20'h0BEEF, 2'b01, 2, 1,   1, 2'd0, 0, 2'd0, 4'h0, 32'h00000000, 1, 7, 0};
    vecs[7]  = '{32'h55559FFF, 1, 20'h00C0D, 2'b11, 1, 1,   1, 2'd1, 0, 2'd0, 4'h0, 32'h00C0DFFF, 0, 6, 0};
    vecs[8]  = '{32'h6666B001, 0, 20'hFFFFF, 2'b10, 0, 1,   1, 2'd3, 0, 2'd0, 4'h0, 32'h00000000, 1, 5, 0};
    vecs[9]  = '{32'h88883000, 0, 20'h12121, 2'b00, 0, 1,   0, 2'd0, 0, 2'd0, 4'h0, 32'h00000000, 1, 4, 5};
    vecs[10] = '{32'h12345000, 0, 20'h00001, 2'b11, 3, 1,   1, 2'd0, 0, 2'd0, 4'h0, 32'h00001000, 0, 8, 0};

    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_fault", 32'(resp_fault), 32'd0);
    chk("rst_resp_paddr", resp_paddr, 32'd0);
    chk("rst_walk_req_valid", 32'(walk_req_valid), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_lru_update_en", 32'(lru_update_en), 32'd0);
    chk("rst_walk_vpn", 32'(walk_req_vpn), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Full set 3 with counts 3,1,1,2: tie between ways 1 and 2 resolves to way 1.
    for (int w = 0; w < 4; w++) begin
      s_valid[3][w] = 1;
      s_vpn[3][w]   = 20'h00003 + 20'(w * 16);
    end
    s_lru[3][0] = 4'd3; s_lru[3][1] = 4'd1; s_lru[3][2] = 4'd1; s_lru[3][3] = 4'd2;
    v = '{32'h33333AAA, 0, 20'h54321, 2'b11, 0, 1, 1, 2'd1, 0, 2'd0, 4'h0, 32'h54321AAA, 0, 5, 0};
    run_vec(20, v);
    for (int w = 0; w < 4; w++) s_valid[3][w] = 0;

    // Reset while waiting on the walker; the late walk response must be ignored.
    w0 = wr_cnt;
    @(negedge clk);
    req_vaddr = 32'h99993000;
    req_write = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 0;
    while (!walk_req_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("rstw_walk_req", 32'(walk_req_valid), 32'd1);
    walk_req_ready = 1'b1;
    @(negedge clk);
    walk_req_ready = 1'b0;
    chk("rstw_in_wait", 32'(walk_req_valid), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("rstw_walk_req_valid", 32'(walk_req_valid), 32'd0);
    chk("rstw_req_ready", 32'(req_ready), 32'd1);
    chk("rstw_resp_valid", 32'(resp_valid), 32'd0);
    chk("rstw_wr_en", 32'(wr_en), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    walk_resp_valid = 1'b1;
    walk_resp_ppn   = 20'h77777;
    walk_resp_perms = 2'b11;
    @(negedge clk);
    walk_resp_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstw_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("rstw_idle", 32'(req_ready), 32'd1);
    chk("rstw_no_resp", 32'(resp_valid), 32'd0);

    run_vec(30, vecs[0]);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
